// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter
// Purpose  : Round-robin arbiter for the single register-file write port,
//            plus the 64-entry pending-writeback scoreboard for the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int NUM_UNITS = 5,
    parameter int RN_W      = 6,
    parameter int DATA_W    = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue_en,
    input  logic [RN_W-1:0]             issue_rd,
    input  logic                        issue_rd2_en,
    input  logic [RN_W-1:0]             issue_rd2,
    input  logic [NUM_UNITS-1:0]        wb_req,
    input  logic [NUM_UNITS*RN_W-1:0]   wb_rn,
    input  logic [NUM_UNITS*DATA_W-1:0] wb_data,
    output logic [NUM_UNITS-1:0]        wb_ack,
    output logic                        rf_we,
    output logic [RN_W-1:0]             rf_wrn,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic [63:0]                 reg_busy,
    output logic                        issue_collide
);

    localparam int c_PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int c_SUM_W = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(NUM_UNITS - 1);

    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [63:0]        r_busy;
    logic               r_rf_we;
    logic [RN_W-1:0]    r_rf_wrn;
    logic [DATA_W-1:0]  r_rf_wdata;
    logic               r_collide;

    logic               w_grant_vld;
    logic [c_PTR_W-1:0] w_grant_idx;
    logic [c_SUM_W-1:0] w_sum;
    logic [c_PTR_W-1:0] w_idx;
    logic [RN_W-1:0]    w_grant_rn;
    logic [DATA_W-1:0]  w_grant_data;
    logic [63:0]        w_busy_next;
    logic               w_collide;

    // Walk the requesters starting at the pointer; the first hit wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_sum = {1'b0, r_rr_ptr} + c_SUM_W'(k);
            if (w_sum >= c_SUM_W'(NUM_UNITS))
                w_sum = w_sum - c_SUM_W'(NUM_UNITS);
            w_idx = w_sum[c_PTR_W-1:0];
            if (!w_grant_vld && wb_req[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_idx;
            end
        end
        if (!rst_n)
            w_grant_vld = 1'b0;
    end

    always_comb begin
        wb_ack       = '0;
        w_grant_rn   = '0;
        w_grant_data = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_grant_vld && (w_grant_idx == c_PTR_W'(i))) begin
                wb_ack[i]    = 1'b1;
                w_grant_rn   = wb_rn[i*RN_W +: RN_W];
                w_grant_data = wb_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Set is applied after clear so a fresh producer keeps the bit pending.
    always_comb begin
        w_busy_next = r_busy;
        if (w_grant_vld)
            w_busy_next[w_grant_rn] = 1'b0;
        if (issue_en)
            w_busy_next[issue_rd] = 1'b1;
        if (issue_en && issue_rd2_en)
            w_busy_next[issue_rd2] = 1'b1;
        w_busy_next[0] = 1'b0;

        w_collide = issue_en &&
                    (((issue_rd != '0) && r_busy[issue_rd]) ||
                     (issue_rd2_en && (issue_rd2 != '0) && r_busy[issue_rd2]));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_busy     <= '0;
            r_rf_we    <= 1'b0;
            r_rf_wrn   <= '0;
            r_rf_wdata <= '0;
            r_collide  <= 1'b0;
        end else begin
            r_busy    <= w_busy_next;
            r_collide <= w_collide;
            r_rf_we   <= w_grant_vld && (w_grant_rn != '0);
            if (w_grant_vld) begin
                r_rf_wrn   <= w_grant_rn;
                r_rf_wdata <= w_grant_data;
                r_rr_ptr   <= (w_grant_idx == c_LAST) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    assign rf_we         = r_rf_we;
    assign rf_wrn        = r_rf_wrn;
    assign rf_wdata      = r_rf_wdata;
    assign reg_busy      = r_busy;
    assign issue_collide = r_collide;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_arbiter
// Purpose  : Directed self-checking bench for writeback_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

    localparam int c_N  = 5;
    localparam int c_RN = 6;
    localparam int c_DW = 64;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   issue_en;
    logic [c_RN-1:0]        issue_rd;
    logic                   issue_rd2_en;
    logic [c_RN-1:0]        issue_rd2;
    logic [c_N-1:0]         wb_req;
    logic [c_N*c_RN-1:0]    wb_rn;
    logic [c_N*c_DW-1:0]    wb_data;
    logic [c_N-1:0]         wb_ack;
    logic                   rf_we;
    logic [c_RN-1:0]        rf_wrn;
    logic [c_DW-1:0]        rf_wdata;
    logic [63:0]            reg_busy;
    logic                   issue_collide;

    int checks = 0;
    int errors = 0;

    writeback_arbiter #(.NUM_UNITS(c_N), .RN_W(c_RN), .DATA_W(c_DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .issue_rd2_en (issue_rd2_en),
        .issue_rd2    (issue_rd2),
        .wb_req       (wb_req),
        .wb_rn        (wb_rn),
        .wb_data      (wb_data),
        .wb_ack       (wb_ack),
        .rf_we        (rf_we),
        .rf_wrn       (rf_wrn),
        .rf_wdata     (rf_wdata),
        .reg_busy     (reg_busy),
        .issue_collide(issue_collide)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int u, input logic [c_RN-1:0] rn, input logic [c_DW-1:0] d);
        wb_rn[u*c_RN +: c_RN]   = rn;
        wb_data[u*c_DW +: c_DW] = d;
    endtask

    task automatic issue(input logic [c_RN-1:0] rd, input logic en2, input logic [c_RN-1:0] rd2);
        issue_en     = 1'b1;
        issue_rd     = rd;
        issue_rd2_en = en2;
        issue_rd2    = rd2;
    endtask

    task automatic no_issue();
        issue_en     = 1'b0;
        issue_rd2_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        no_issue();
        issue_rd  = '0;
        issue_rd2 = '0;
        wb_req    = 5'b11111;
        wb_rn     = '0;
        wb_data   = '0;
        for (int u = 0; u < c_N; u++)
            set_unit(u, c_RN'(10 + u), 64'h100 + 64'(u));

        // Reset held with every unit requesting
        step();
        step();
        check("rst_ack", 64'(wb_ack), 64'h0);
        check("rst_we", 64'(rf_we), 64'h0);
        check("rst_busy", reg_busy, 64'h0);
        check("rst_collide", 64'(issue_collide), 64'h0);

        rst_n = 1'b1;
        #1;
        check("first_grant", 64'(wb_ack), 64'h1);

        // Continuous requests from all units rotate through 0..4 twice
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("rr_ack_%0d", c), 64'(wb_ack), 64'(1 << (c % 5)));
            step();
            check($sformatf("rr_we_%0d", c), 64'(rf_we), 64'h1);
            check($sformatf("rr_wrn_%0d", c), 64'(rf_wrn), 64'(10 + (c % 5)));
            check($sformatf("rr_wdata_%0d", c), rf_wdata, 64'h100 + 64'(c % 5));
        end
        wb_req = '0;
        #1;
        check("idle_ack", 64'(wb_ack), 64'h0);
        step();
        check("idle_we", 64'(rf_we), 64'h0);
        check("idle_wrn_hold", 64'(rf_wrn), 64'd14);

        // Issue rd 12, then alu2 writes it back
        issue(6'd12, 1'b0, 6'd0);
        step();
        no_issue();
        check("busy12_set", 64'(reg_busy[12]), 64'h1);
        set_unit(1, 6'd12, 64'hDEAD);
        wb_req = 5'b00010;
        #1;
        check("alu2_ack", 64'(wb_ack), 64'h2);
        step();
        wb_req = '0;
        check("wb12_we", 64'(rf_we), 64'h1);
        check("wb12_wrn", 64'(rf_wrn), 64'd12);
        check("wb12_wdata", rf_wdata, 64'hDEAD);
        check("busy12_clr", reg_busy, 64'h0);

        // Issue and writeback of rn 7 in the same cycle: set wins
        issue(6'd7, 1'b0, 6'd0);
        set_unit(3, 6'd7, 64'h77);
        wb_req = 5'b01000;
        #1;
        check("mem_ack", 64'(wb_ack), 64'h8);
        step();
        no_issue();
        wb_req = '0;
        check("busy7_kept", reg_busy, 64'h80);
        check("wb7_we", 64'(rf_we), 64'h1);
        check("wb7_wrn", 64'(rf_wrn), 64'd7);
        check("wb7_wdata", rf_wdata, 64'h77);
        check("wb7_collide", 64'(issue_collide), 64'h0);

        // r0 is never tracked and never written
        issue(6'd0, 1'b0, 6'd0);
        step();
        no_issue();
        check("busy_r0", reg_busy, 64'h80);
        set_unit(4, 6'd0, 64'h1234);
        wb_req = 5'b10000;
        #1;
        check("br_ack", 64'(wb_ack), 64'h10);
        step();
        wb_req = '0;
        check("r0_we", 64'(rf_we), 64'h0);

        // advint dual destination, cleared one beat at a time
        issue(6'd20, 1'b1, 6'd21);
        step();
        no_issue();
        check("busy_20_21", reg_busy, 64'h0000_0000_0030_0080);
        check("dual_collide", 64'(issue_collide), 64'h0);
        set_unit(2, 6'd20, 64'hA20);
        wb_req = 5'b00100;
        #1;
        check("adv_ack1", 64'(wb_ack), 64'h4);
        step();
        set_unit(2, 6'd21, 64'hA21);
        check("adv1_wrn", 64'(rf_wrn), 64'd20);
        check("adv1_busy", reg_busy, 64'h0000_0000_0020_0080);
        #1;
        check("adv_ack2", 64'(wb_ack), 64'h4);
        step();
        wb_req = '0;
        check("adv2_wrn", 64'(rf_wrn), 64'd21);
        check("adv2_wdata", rf_wdata, 64'hA21);
        check("adv2_busy", reg_busy, 64'h80);

        // Re-issue to a busy rn raises a one-cycle collide pulse
        issue(6'd20, 1'b0, 6'd0);
        step();
        check("reiss_first", 64'(issue_collide), 64'h0);
        step();
        no_issue();
        check("reiss_collide", 64'(issue_collide), 64'h1);
        step();
        check("collide_pulse", 64'(issue_collide), 64'h0);

        // rd == rd2 self-overlap sets one bit without a collide
        issue(6'd30, 1'b1, 6'd30);
        step();
        no_issue();
        check("self_busy", reg_busy, 64'h0000_0000_4010_0080);
        check("self_collide", 64'(issue_collide), 64'h0);

        // Collide detected through the second destination
        issue(6'd40, 1'b1, 6'd7);
        step();
        no_issue();
        check("rd2_collide", 64'(issue_collide), 64'h1);

        // Reset mid-transaction drops the write and clears the scoreboard
        wb_req = 5'b00001;
        rst_n  = 1'b0;
        #1;
        check("midrst_ack", 64'(wb_ack), 64'h0);
        step();
        check("midrst_we", 64'(rf_we), 64'h0);
        check("midrst_busy", reg_busy, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
